rectangle_round_ctrl: RTL and testbench

Sequencing controller for the RECTANGLE-128 block cipher core. On each request it decides whether the round-key file must be rebuilt: it compares the master key against a cached copy and, when needed, drives the key-schedule engine to write all 26 round keys. It then drives the round datapath through load, 25 rounds and final key addition. Round keys are read in forward order for encryption and reverse order for decryption. It sits between the top-level request interface (Enable/Encrypt/cipherReady) and the key-schedule, round-key-file and round-datapath sub-blocks.

---
 rtl/rectangle_pkg.sv | 10 +
 rtl/rectangle_raddr_gen.sv | 26 ++
 rtl/rectangle_round_ctrl.sv | 100 ++++++++++
 tb/tb_rectangle_round_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rectangle_pkg.sv
// Shared RECTANGLE-128 constants and controller state encoding.
package rectangle_pkg;
  localparam int NR = 25;
  localparam int AW = 5;
  localparam int KW = 64;

  typedef enum logic [2:0] {
    IDLE, FLUSH, KLOAD, KEXP, RUN, DONE
  } rect_state_t;
endpackage

// File: rtl/rectangle_raddr_gen.sv
// Round-key read address and round strobes; forward order for encrypt, reverse for decrypt.
module rectangle_raddr_gen
  import rectangle_pkg::*;
(
  input  logic          run,
  input  logic [AW-1:0] rcnt,
  input  logic          enc_q,
  output logic [AW-1:0] raddr,
  output logic          dp_round,
  output logic          dp_last
);
  always_comb begin
    raddr    = '0;
    dp_round = 1'b0;
    dp_last  = 1'b0;
    if (run) begin
      if (rcnt == AW'(NR + 1)) begin
        dp_last = 1'b1;
        raddr   = enc_q ? AW'(NR) : '0;
      end else if (rcnt != '0) begin
        dp_round = 1'b1;
        raddr    = enc_q ? (rcnt - AW'(1)) : (AW'(NR) - (rcnt - AW'(1)));
      end
    end
  end
endmodule

// File: rtl/rectangle_round_ctrl.sv
// RECTANGLE-128 sequencer: key-cache check, round-key expansion, then load/rounds/final XOR.
module rectangle_round_ctrl
  import rectangle_pkg::*;
(
  input  logic          Clk,
  input  logic          RstN,
  input  logic          Enable,
  input  logic          Encrypt,
  input  logic [KW-1:0] key0,
  input  logic [KW-1:0] key1,
  output logic          ks_load,
  output logic          ks_step,
  input  logic [KW-1:0] ks_subkey,
  output logic          flush,
  output logic          WE,
  output logic [AW-1:0] WAddr,
  output logic [KW-1:0] KeyIn,
  output logic          skey_ready,
  output logic [AW-1:0] RAddr,
  output logic          dp_load,
  output logic          dp_round,
  output logic          dp_last,
  output logic          cipherReady
);
  rect_state_t     state, nxt;
  logic [2*KW-1:0] key_q;
  logic            enc_q;
  logic [AW-1:0]   wcnt, rcnt;
  logic            hit;

  assign hit = skey_ready && ({key1, key0} == key_q);

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state      <= IDLE;
      key_q      <= '0;
      enc_q      <= 1'b0;
      skey_ready <= 1'b0;
      wcnt       <= '0;
      rcnt       <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE:  if (Enable) enc_q <= Encrypt;
        FLUSH: begin
          skey_ready <= 1'b0;
          key_q      <= {key1, key0};
        end
        KLOAD: wcnt <= '0;
        KEXP: begin
          if (wcnt == AW'(NR)) begin
            if (Enable) skey_ready <= 1'b1;
            wcnt <= '0;
          end else begin
            wcnt <= wcnt + AW'(1);
          end
        end
        RUN:   rcnt <= (rcnt == AW'(NR + 1)) ? '0 : rcnt + AW'(1);
        default: ;
      endcase
      // An abort returns to IDLE with clean counters; the cache flag is untouched.
      if (!Enable) begin
        wcnt <= '0;
        rcnt <= '0;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (Enable) nxt = hit ? RUN : FLUSH;
      FLUSH: nxt = KLOAD;
      KLOAD: nxt = KEXP;
      KEXP:  if (wcnt == AW'(NR)) nxt = RUN;
      RUN:   if (rcnt == AW'(NR + 1)) nxt = DONE;
      DONE:  nxt = DONE;
      default: nxt = IDLE;
    endcase
    if (state != IDLE && !Enable) nxt = IDLE;
  end

  assign flush       = (state == FLUSH);
  assign ks_load     = (state == KLOAD);
  assign WE          = (state == KEXP);
  assign WAddr       = (state == KEXP) ? wcnt : '0;
  assign ks_step     = (state == KEXP) && (wcnt < AW'(NR));
  assign KeyIn       = ks_subkey;
  assign dp_load     = (state == RUN) && (rcnt == '0);
  assign cipherReady = (state == DONE);

  rectangle_raddr_gen u_raddr (
    .run      (state == RUN),
    .rcnt     (rcnt),
    .enc_q    (enc_q),
    .raddr    (RAddr),
    .dp_round (dp_round),
    .dp_last  (dp_last)
  );
endmodule

// File: tb/tb_rectangle_round_ctrl.sv
// Directed bench for the RECTANGLE-128 sequencer with a counting key-schedule stand-in.
module tb_rectangle_round_ctrl;
  import rectangle_pkg::*;

  localparam logic [63:0] KBASE = 64'h0F0F_1234_0000_0000;
  localparam logic [63:0] KINC  = 64'h0000_0000_0000_1111;
  localparam logic [63:0] KA    = 64'hAABB_0918_2736_CCDD;
  localparam logic [63:0] KB    = 64'h0011_2233_4455_6677;
  localparam logic [63:0] KC    = 64'hDEAD_BEEF_0BAD_F00D;

  logic          Clk = 1'b0, RstN = 1'b0, Enable = 1'b0, Encrypt = 1'b0;
  logic [KW-1:0] key0 = '0, key1 = '0;
  logic          ks_load, ks_step, flush, WE, skey_ready, dp_load, dp_round, dp_last, cipherReady;
  logic [AW-1:0] WAddr, RAddr;
  logic [KW-1:0] KeyIn, ks_subkey;
  logic [KW-1:0] ks_reg = '0;

  int checks = 0, failures = 0;

  rectangle_round_ctrl dut (
    .Clk(Clk), .RstN(RstN), .Enable(Enable), .Encrypt(Encrypt), .key0(key0), .key1(key1),
    .ks_load(ks_load), .ks_step(ks_step), .ks_subkey(ks_subkey), .flush(flush), .WE(WE),
    .WAddr(WAddr), .KeyIn(KeyIn), .skey_ready(skey_ready), .RAddr(RAddr), .dp_load(dp_load),
    .dp_round(dp_round), .dp_last(dp_last), .cipherReady(cipherReady)
  );

  always #5 Clk = ~Clk;

  // Key-schedule stand-in: subkey i reads as KBASE + i*KINC.
  always @(posedge Clk) begin
    if (ks_load)      ks_reg <= KBASE;
    else if (ks_step) ks_reg <= ks_reg + KINC;
  end
  assign ks_subkey = ks_reg;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint outs();
    return longint'({ks_load, ks_step, flush, WE, WAddr, skey_ready, RAddr,
                     dp_load, dp_round, dp_last, cipherReady});
  endfunction

  task automatic run_op(input string nm, input bit enc, input logic [63:0] k0, input logic [63:0] k1,
                        input int exp_lat, input int exp_fl, input int exp_wr, input bit hold);
    int cyc = 0, nfl = 0, nwr = 0, nks = 0, nld = 0, nrd = 0, nls = 0;
    int waerr = 0, kerr = 0, raerr = 0, ra;
    bit done = 0;
    Enable = 1'b1; Encrypt = enc; key0 = k0; key1 = k1;
    while (!done && cyc < 200) begin
      @(posedge Clk); cyc++;
      @(negedge Clk);
      if (flush) nfl++;
      if (ks_step) nks++;
      if (WE) begin
        if (int'(WAddr) != nwr) waerr++;
        if (KeyIn != KBASE + KINC * 64'(nwr)) kerr++;
        nwr++;
      end
      if (dp_load) nld++;
      if (dp_round) begin
        ra = enc ? nrd : NR - nrd;
        if (int'(RAddr) != ra) raerr++;
        nrd++;
      end
      if (dp_last) begin
        ra = enc ? NR : 0;
        if (int'(RAddr) != ra) raerr++;
        nls++;
      end
      if (cipherReady) done = 1;
    end
    chk({nm, " latency"}, cyc, exp_lat);
    chk({nm, " flush pulses"}, nfl, exp_fl);
    chk({nm, " writes"}, nwr, exp_wr);
    chk({nm, " ks_step pulses"}, nks, exp_wr > 0 ? NR : 0);
    chk({nm, " waddr seq errors"}, waerr, 0);
    chk({nm, " keyin errors"}, kerr, 0);
    chk({nm, " raddr seq errors"}, raerr, 0);
    chk({nm, " dp_load pulses"}, nld, 1);
    chk({nm, " dp_round pulses"}, nrd, NR);
    chk({nm, " dp_last pulses"}, nls, 1);
    chk({nm, " skey_ready"}, skey_ready, 1);
    if (!hold) begin
      Enable = 1'b0;
      @(posedge Clk); @(negedge Clk);
      chk({nm, " cipherReady drop"}, cipherReady, 0);
    end
  endtask

  typedef struct {
    string       nm;
    bit          enc;
    logic [63:0] k0, k1;
    int          lat, fl, wr;
  } vec_t;
  vec_t tbl[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n;
    tbl[0] = '{"cold_enc", 1'b1, KA, KA, 56, 1, 26};
    tbl[1] = '{"hit_dec",  1'b0, KA, KA, 28, 0, 0};
    tbl[2] = '{"newkey",   1'b1, KA, KB, 56, 1, 26};
    tbl[3] = '{"hit_enc",  1'b1, KA, KB, 28, 0, 0};

    repeat (3) @(negedge Clk);
    chk("reset outputs", outs(), 0);
    RstN = 1'b1;
    @(negedge Clk);
    chk("idle outputs", outs(), 0);

    foreach (tbl[i]) run_op(tbl[i].nm, tbl[i].enc, tbl[i].k0, tbl[i].k1, tbl[i].lat, tbl[i].fl, tbl[i].wr, 1'b0);

    // Abort during expansion at write address 10.
    Enable = 1'b1; Encrypt = 1'b1; key0 = KA; key1 = KC;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge Clk); @(negedge Clk);
      if (WE && WAddr == 5'd10) found = 1;
    end
    chk("kexp abort reached wcnt10", found, 1);
    Enable = 1'b0;
    @(posedge Clk); @(negedge Clk);
    chk("kexp abort WE", WE, 0);
    chk("kexp abort skey_ready", skey_ready, 0);
    run_op("after_kexp_abort", 1'b1, KA, KC, 56, 1, 26, 1'b0);

    // Abort in the middle of RUN keeps the cache.
    Enable = 1'b1; Encrypt = 1'b0;
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(posedge Clk); @(negedge Clk);
      if (dp_round) n++;
    end
    chk("run abort rounds seen", n, 10);
    Enable = 1'b0;
    @(posedge Clk); @(negedge Clk);
    chk("run abort dp_round", dp_round, 0);
    chk("run abort skey_ready", skey_ready, 1);
    run_op("after_run_abort", 1'b0, KA, KC, 28, 0, 0, 1'b0);

    // Asynchronous reset while in DONE.
    run_op("pre_reset", 1'b1, KA, KC, 28, 0, 0, 1'b1);
    #2 RstN = 1'b0;
    #1 chk("async reset outputs", outs(), 0);
    Enable = 1'b0;
    @(negedge Clk);
    RstN = 1'b1;
    @(negedge Clk);
    run_op("post_reset", 1'b1, KA, KC, 56, 1, 26, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
